// File: rtl/mult_pkg.sv
// Shared types and defaults for the iterative multiplier family.
package mult_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mult_sign_fix.sv
// Conditional two's-complement negate: yields |x| on the way in and
// restores the sign of the result on the way out.
module mult_sign_fix #(
  parameter int W = 8
) (
  input  logic [W-1:0] data_i,
  input  logic         neg_i,
  output logic [W-1:0] data_o
);

  assign data_o = neg_i ? (~data_i + W'(1)) : data_i;

endmodule

// File: rtl/seq_mult.sv
// Iterative shift-add multiplier with valid/ready handshakes on both sides.
// Signed operands are multiplied as magnitudes and the sign is fixed at the end.
module seq_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   ma_q, ma_d;
  logic [WIDTH-1:0]     mb_q, mb_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [WIDTH-1:0]     magA, magB;
  logic [2*WIDTH-1:0]   accSum, signedResult;

  // The magnitude of the most negative value still fits as an unsigned WIDTH-bit number.
  mult_sign_fix #(.W(WIDTH)) uFixA (
    .data_i(a),
    .neg_i (is_signed & a[WIDTH-1]),
    .data_o(magA)
  );

  mult_sign_fix #(.W(WIDTH)) uFixB (
    .data_i(b),
    .neg_i (is_signed & b[WIDTH-1]),
    .data_o(magB)
  );

  assign accSum = mb_q[0] ? (acc_q + ma_q) : acc_q;

  mult_sign_fix #(.W(2 * WIDTH)) uFixResult (
    .data_i(accSum),
    .neg_i (neg_q),
    .data_o(signedResult)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign product   = product_q;

  always_comb begin
    state_d   = state_q;
    ma_d      = ma_q;
    mb_d      = mb_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    product_d = product_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          ma_d    = {{WIDTH{1'b0}}, magA};
          mb_d    = magB;
          neg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = accSum;
        ma_d  = ma_q << 1;
        mb_d  = mb_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        // Always run the full WIDTH iterations so latency is data-independent.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          product_d = signedResult;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ma_q      <= '0;
      mb_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      ma_q      <= ma_d;
      mb_q      <= mb_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

endmodule

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult at WIDTH=4, 8 and 16: directed vectors,
// multi-cycle corner sequences and a randomized regression against an integer model.
module tb_seq_mult;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] aBus, bBus;
  logic        isSigned;
  logic        outReady;
  logic [2:0]  inValid, inReady, outValid, busyV;
  logic [7:0]  prod4;
  logic [15:0] prod8;
  logic [31:0] prod16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_mult #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid[0]), .in_ready(inReady[0]),
    .a(aBus[3:0]), .b(bBus[3:0]), .is_signed(isSigned), .out_valid(outValid[0]),
    .out_ready(outReady), .product(prod4), .busy(busyV[0])
  );

  seq_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid[1]), .in_ready(inReady[1]),
    .a(aBus[7:0]), .b(bBus[7:0]), .is_signed(isSigned), .out_valid(outValid[1]),
    .out_ready(outReady), .product(prod8), .busy(busyV[1])
  );

  seq_mult #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid[2]), .in_ready(inReady[2]),
    .a(aBus), .b(bBus), .is_signed(isSigned), .out_valid(outValid[2]),
    .out_ready(outReady), .product(prod16), .busy(busyV[2])
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [31:0] exp;
  } vec_t;

  function automatic int widthOf(int idx);
    case (idx)
      0:       return 4;
      1:       return 8;
      default: return 16;
    endcase
  endfunction

  function automatic logic [31:0] prodOf(int idx);
    case (idx)
      0:       return {24'b0, prod4};
      1:       return {16'b0, prod8};
      default: return prod16;
    endcase
  endfunction

  // Integer product of the operands interpreted at width w, wrapped to 2*w bits.
  function automatic logic [31:0] refMul(int w, logic [15:0] a, logic [15:0] b, logic s);
    longint m, va, vb, p;
    m  = longint'(1) << w;
    va = longint'(a) & (m - 1);
    vb = longint'(b) & (m - 1);
    if (s && va >= m / 2) va = va - m;
    if (s && vb >= m / 2) vb = vb - m;
    p = va * vb;
    return 32'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One full transaction: accept, wait for the result, stall, then handshake.
  task automatic applyStimulus(input int idx, input logic [15:0] a, input logic [15:0] b,
                               input logic s, input int stalls, input bit intrude,
                               input logic [31:0] exp, input string tag);
    int cyc;
    int w;
    w = widthOf(idx);
    @(negedge clk);
    aBus = a; bBus = b; isSigned = s; inValid[idx] = 1'b1;
    @(negedge clk);
    inValid[idx] = 1'b0;
    aBus = 16'($urandom); bBus = 16'($urandom); isSigned = 1'($urandom);
    cyc = 1;
    while (!outValid[idx] && cyc < 200) begin
      if (intrude && cyc == 3) begin
        aBus = 16'h00AA; bBus = 16'h0055; inValid[idx] = 1'b1;
      end else begin
        inValid[idx] = 1'b0;
      end
      outReady = 1'($urandom_range(0, 1));
      @(negedge clk);
      cyc++;
    end
    inValid[idx] = 1'b0;
    outReady = 1'b0;
    checkOutput({tag, " latency"}, 32'(cyc - 1), 32'(w));
    checkOutput({tag, " product"}, prodOf(idx), exp);
    checkOutput({tag, " in_ready low"}, {31'b0, inReady[idx]}, 32'd0);
    for (int i = 0; i < stalls; i++) begin
      @(negedge clk);
      checkOutput({tag, " stall hold"}, {inReady[idx], outValid[idx], busyV[idx]}, 32'b011);
      checkOutput({tag, " stall product"}, prodOf(idx), exp);
    end
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
    checkOutput({tag, " handshake"}, {inReady[idx], outValid[idx], busyV[idx]}, 32'b100);
    checkOutput({tag, " product kept"}, prodOf(idx), exp);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[10];
    logic [15:0] ra, rb, mask;
    logic        rs;
    int          w, cyc;
    logic [15:0] corner[4];

    vecs[0] = '{16'h00FF, 16'h00FF, 1'b0, 32'h0000FE01};
    vecs[1] = '{16'h00FD, 16'h0005, 1'b1, 32'h0000FFF1};
    vecs[2] = '{16'h0080, 16'h0080, 1'b1, 32'h00004000};
    vecs[3] = '{16'h0080, 16'h0001, 1'b1, 32'h0000FF80};
    vecs[4] = '{16'h0000, 16'h00F9, 1'b1, 32'h00000000};
    vecs[5] = '{16'h00F9, 16'h0000, 1'b1, 32'h00000000};
    vecs[6] = '{16'h0001, 16'h00FF, 1'b0, 32'h000000FF};
    vecs[7] = '{16'h00FF, 16'h00FF, 1'b1, 32'h00000001};
    vecs[8] = '{16'h007F, 16'h0080, 1'b1, 32'h0000C080};
    vecs[9] = '{16'h0080, 16'h0080, 1'b0, 32'h00004000};

    rst_n = 1'b0; inValid = '0; aBus = '0; bBus = '0; isSigned = 1'b0; outReady = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    checkOutput("reset in_ready", {29'b0, inReady}, 32'b111);
    checkOutput("reset out_valid", {29'b0, outValid}, 32'b000);
    checkOutput("reset busy", {29'b0, busyV}, 32'b000);
    checkOutput("reset product8", prodOf(1), 32'h0);
    checkOutput("reset product16", prodOf(2), 32'h0);

    for (int i = 0; i < 10; i++)
      applyStimulus(1, vecs[i].a, vecs[i].b, vecs[i].s, i % 3, 1'b0, vecs[i].exp,
                    $sformatf("vec%0d", i));

    applyStimulus(1, 16'h00FD, 16'h0005, 1'b1, 5, 1'b0, 32'h0000FFF1, "backpressure");
    applyStimulus(1, 16'h0003, 16'h0004, 1'b0, 0, 1'b1, 32'h0000000C, "busyIgnore");

    // Abandon an operation after three iterations; no result may appear.
    @(negedge clk);
    aBus = 16'h0020; bBus = 16'h0030; isSigned = 1'b0; inValid[1] = 1'b1;
    @(negedge clk);
    inValid[1] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("midReset state", {inReady[1], outValid[1], busyV[1]}, 32'b100);
    checkOutput("midReset product", prodOf(1), 32'h0);
    cyc = 0;
    repeat (12) begin
      @(negedge clk);
      if (outValid[1]) cyc++;
    end
    checkOutput("midReset no out_valid", 32'(cyc), 32'd0);
    applyStimulus(1, 16'h0081, 16'h0002, 1'b1, 1, 1'b0, 32'h0000FF02, "postReset");

    // Reset and output handshake on the same edge: reset must clear the product.
    @(negedge clk);
    aBus = 16'h0005; bBus = 16'h0005; isSigned = 1'b0; inValid[1] = 1'b1;
    @(negedge clk);
    inValid[1] = 1'b0;
    cyc = 0;
    while (!outValid[1] && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("resetWins reached DONE", {31'b0, outValid[1]}, 32'd1);
    rst_n = 1'b0; outReady = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; outReady = 1'b0;
    checkOutput("resetWins state", {inReady[1], outValid[1], busyV[1]}, 32'b100);
    checkOutput("resetWins product", prodOf(1), 32'h0);

    for (int idx = 0; idx < 3; idx++) begin
      w = widthOf(idx);
      mask = 16'((32'd1 << w) - 1);
      corner[0] = 16'h0;
      corner[1] = mask;
      corner[2] = 16'(32'd1 << (w - 1));
      corner[3] = 16'h1;
      for (int n = 0; n < 340; n++) begin
        ra = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : (16'($urandom) & mask);
        rb = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : (16'($urandom) & mask);
        rs = 1'($urandom_range(0, 1));
        applyStimulus(idx, ra, rb, rs, $urandom_range(0, 3), 1'b0, refMul(w, ra, rb, rs),
                      $sformatf("rand w%0d #%0d a=%0h b=%0h s=%0d", w, n, ra, rb, rs));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
